// File: rtl/bce_batch_loss_accumulator_pkg.sv
// Shared FP32 constants and accumulator state encodings.
// Used by: bce_acc_ctrl, bce_batch_loss_accumulator.
// No ports.
package bce_batch_loss_accumulator_pkg;

    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam int          FP32_EXP_MSB = 30;
    localparam int          FP32_EXP_LSB = 23;

    localparam logic [1:0] ACC_S_ACCUM = 2'd0;
    localparam logic [1:0] ACC_S_SCALE = 2'd1;
    localparam logic [1:0] ACC_S_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_ACCUM = ACC_S_ACCUM,
        ST_SCALE = ACC_S_SCALE,
        ST_HOLD  = ACC_S_HOLD
    } acc_state_t;

    // True for Inf and NaN encodings (all-ones exponent).
    function automatic logic fp32_exp_all_ones(input logic [31:0] v);
        return v[FP32_EXP_MSB:FP32_EXP_LSB] == 8'hFF;
    endfunction

endpackage

// File: rtl/bce_acc_ctrl.sv
// Batch sequencing FSM and sample counter for the loss accumulator.
// Ports: clk, rst_n, flush, in_valid, out_ready (inputs);
//        in_ready, out_valid, sample_cnt, acc_en, acc_clr, scale_en (outputs).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_ACCUM | accepting samples, summing into acc
// ST_SCALE | one cycle: mean_loss <= acc * INV_BATCH
// ST_HOLD  | mean_loss presented, waiting for out_ready
module bce_acc_ctrl
    import bce_batch_loss_accumulator_pkg::*;
#(
    parameter int BATCH_SIZE = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             scale_en
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH_SIZE - 1);

    acc_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACCUM;
            sample_cnt <= '0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = sample_cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        scale_en  = 1'b0;
        unique case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    acc_en = 1'b1;
                    if (sample_cnt == LAST_CNT) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_SCALE;
                    end else begin
                        cnt_nxt = sample_cnt + CNT_W'(1);
                    end
                end
            end
            ST_SCALE: begin
                if (!flush) begin
                    scale_en  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_clr   = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase
        // Flush overrides any handshake in the same cycle.
        if (flush) begin
            acc_clr   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_ACCUM;
        end
    end

endmodule

// File: rtl/spfp_adder_subtractor.sv
// Combinational FP32 adder/subtractor (result = a + b, or a - b when sub=1).
// Truncating rounding, denormal inputs/outputs flushed to zero,
// NaN yields canonical quiet NaN, Inf propagates, Inf - Inf gives NaN.
// Ports: a, b (FP32 operands), sub (1 = subtract), result (FP32).
module spfp_adder_subtractor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_big;
    logic        s_big, s_small;
    logic [7:0]  e_big, e_small, e_diff;
    logic [23:0] f_big, f_small;
    logic [27:0] mag, norm;
    logic [22:0] mant;
    int          lead;
    int          e_res;

    assign sa    = a[31];
    assign sb    = b[31] ^ sub;
    assign ea    = a[30:23];
    assign eb    = b[30:23];
    assign ma    = a[22:0];
    assign mb    = b[22:0];
    assign a_nan = (ea == 8'hFF) && (ma != 23'd0);
    assign b_nan = (eb == 8'hFF) && (mb != 23'd0);
    assign a_inf = (ea == 8'hFF) && (ma == 23'd0);
    assign b_inf = (eb == 8'hFF) && (mb == 23'd0);
    assign a_big = {ea, ma} >= {eb, mb};

    always_comb begin
        s_big   = a_big ? sa : sb;
        s_small = a_big ? sb : sa;
        e_big   = a_big ? ea : eb;
        e_small = a_big ? eb : ea;
        f_big   = (e_big == 8'd0)   ? 24'd0 : {1'b1, (a_big ? ma : mb)};
        f_small = (e_small == 8'd0) ? 24'd0 : {1'b1, (a_big ? mb : ma)};
        e_diff  = e_big - e_small;

        // Three guard bits below the mantissa, one carry bit above.
        if (s_big == s_small)
            mag = {1'b0, f_big, 3'b000} + ({1'b0, f_small, 3'b000} >> e_diff);
        else
            mag = {1'b0, f_big, 3'b000} - ({1'b0, f_small, 3'b000} >> e_diff);

        lead = 0;
        for (int i = 0; i < 28; i++) begin
            if (mag[i]) lead = i;
        end
        norm  = mag << (27 - lead);
        mant  = 23'(norm >> 4);
        e_res = int'(e_big) + lead - 26;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            result = 32'h7FC0_0000;
        else if (a_inf)
            result = {sa, 8'hFF, 23'd0};
        else if (b_inf)
            result = {sb, 8'hFF, 23'd0};
        else if (mag == 28'd0)
            result = 32'h0000_0000;
        else if (e_res >= 255)
            result = {s_big, 8'hFF, 23'd0};
        else if (e_res <= 0)
            result = {s_big, 31'd0};
        else
            result = {s_big, 8'(e_res), mant};
    end

endmodule

// File: rtl/spfp_multiplier.sv
// Combinational FP32 multiplier (result = a * b).
// Truncating rounding, denormals flushed to zero, NaN yields canonical quiet
// NaN, Inf propagates, Inf * 0 gives NaN.
// Ports: a, b (FP32 operands), result (FP32).
module spfp_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [22:0] mant;
    int          e_res;

    assign s      = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign ma     = a[22:0];
    assign mb     = b[22:0];
    assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    always_comb begin
        prod = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
        // Product of two [1,2) mantissas lies in [1,4); renormalise by one bit.
        if (prod[47]) begin
            mant  = 23'(prod >> 24);
            e_res = int'(ea) + int'(eb) - 126;
        end else begin
            mant  = 23'(prod >> 23);
            e_res = int'(ea) + int'(eb) - 127;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            result = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            result = {s, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            result = {s, 31'd0};
        else if (e_res >= 255)
            result = {s, 8'hFF, 23'd0};
        else if (e_res <= 0)
            result = {s, 31'd0};
        else
            result = {s, 8'(e_res), mant};
    end

endmodule

// File: rtl/bce_batch_loss_accumulator.sv
// Batch mean of FP32 per-sample BCE losses: sums BATCH_SIZE accepted samples,
// multiplies by INV_BATCH (must equal 1/BATCH_SIZE) and holds the mean on a
// valid/ready output until taken.
// Ports: clk, rst_n, flush, loss_val[31:0], in_valid, out_ready (inputs);
//        in_ready, mean_loss[31:0], out_valid, sample_cnt[CNT_W-1:0] (outputs);
//        nan_flag (output, only with BCE_ACC_NAN_FLAG_EN defined).
// Build option: BCE_ACC_NAN_FLAG_EN adds a sticky per-batch Inf/NaN input flag.
module bce_batch_loss_accumulator
    import bce_batch_loss_accumulator_pkg::*;
#(
    parameter int          BATCH_SIZE = 4,
    parameter logic [31:0] INV_BATCH  = 32'h3E80_0000,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [31:0]      loss_val,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      mean_loss,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_cnt
`ifdef BCE_ACC_NAN_FLAG_EN
    ,
    output logic             nan_flag
`endif
);

    logic        acc_en, acc_clr, scale_en;
    logic [31:0] acc, acc_sum, acc_scaled;

    bce_acc_ctrl #(
        .BATCH_SIZE (BATCH_SIZE),
        .CNT_W      (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .sample_cnt (sample_cnt),
        .acc_en     (acc_en),
        .acc_clr    (acc_clr),
        .scale_en   (scale_en)
    );

    spfp_adder_subtractor u_add (
        .a      (acc),
        .b      (loss_val),
        .sub    (1'b0),
        .result (acc_sum)
    );

    spfp_multiplier u_mul (
        .a      (acc),
        .b      (INV_BATCH),
        .result (acc_scaled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= FP32_ZERO;
            mean_loss <= FP32_ZERO;
        end else begin
            if (acc_clr)
                acc <= FP32_ZERO;
            else if (acc_en)
                acc <= acc_sum;
            if (scale_en)
                mean_loss <= acc_scaled;
        end
    end

`ifdef BCE_ACC_NAN_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nan_flag <= 1'b0;
        else if (acc_clr)
            nan_flag <= 1'b0;
        else if (acc_en && fp32_exp_all_ones(loss_val))
            nan_flag <= 1'b1;
    end
`endif

endmodule
